hyp_mag_sched: RTL and testbench

Round-robin scheduler that shares one iterative magnitude engine, floor(sqrt(x²+y²)), among NREQ requesters. Each requester presents an (x, y) operand pair with a valid/ready handshake. The block grants one requester at a time and sequences the engine through its square and square-root phases. It returns the result with the requester id on a single valid/ready response port, and sits between the per-channel input registers and the output mux of the chip top.

---
 rtl/hyp_mag_sched_pkg.sv | 31 +++
 rtl/hyp_mag_core.sv | 113 +++++++++++
 rtl/hyp_mag_sched.sv | 133 +++++++++++++
 tb/tb_hyp_mag_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyp_mag_sched_pkg.sv
// Shared definitions for the hyp_mag_sched magnitude scheduler:
// FSM state encoding, default sizes and phase lengths.
package hyp_mag_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_SQRT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Default geometry.
    localparam int DEF_W    = 8;
    localparam int DEF_NREQ = 4;

    // Phase lengths for the default width: one multiplier bit per MUL cycle,
    // one root bit per SQRT cycle.
    localparam int DEF_MUL_CYC  = DEF_W;
    localparam int DEF_SQRT_CYC = DEF_W + 1;

    // Phase lengths for an arbitrary operand width.
    function automatic int mul_cycles(input int w);
        return w;
    endfunction

    function automatic int sqrt_cycles(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/hyp_mag_core.sv
// Iterative magnitude datapath: shift-add squaring of x and y in parallel,
// then a restoring bit-serial square root of x^2+y^2. The phase counter lives
// here; the owning FSM steers it with start/mul_en/sqrt_en and watches the
// *_last flags to move between phases.
module hyp_mag_core
    import hyp_mag_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mul_en,
    input  logic         sqrt_en,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         mul_last,
    output logic         sqrt_last,
    output logic [W:0]   root_next
);

    localparam int AW       = 2 * W;        // square accumulator width
    localparam int RADW     = 2 * W + 2;    // zero-extended radicand width
    localparam int RW       = W + 4;        // remainder width with headroom
    localparam int MUL_CYC  = mul_cycles(W);
    localparam int SQRT_CYC = sqrt_cycles(W);
    localparam int CW       = $clog2(SQRT_CYC + 1);

    logic [AW-1:0]   mc_x_reg, mc_y_reg;     // shifting multiplicands
    logic [W-1:0]    mp_x_reg, mp_y_reg;     // shifting multipliers
    logic [AW-1:0]   acc_x_reg, acc_y_reg;   // partial squares
    logic [RADW-1:0] rad_reg;                // radicand, consumed 2 bits at a time
    logic [RW-1:0]   rem_reg;                // restoring remainder
    logic [W:0]      root_reg;               // partial root
    logic [CW-1:0]   cnt_reg;                // cycle within current phase

    logic [AW-1:0]   acc_x_next, acc_y_next;
    logic [AW:0]     sum_sq;
    logic [RW+1:0]   rem_sh;
    logic [RW+1:0]   trial;
    logic            sqrt_ge;
    logic [RW-1:0]   rem_next;

    assign mul_last  = (cnt_reg == CW'(MUL_CYC - 1));
    assign sqrt_last = (cnt_reg == CW'(SQRT_CYC - 1));

    // One shift-add step per operand, and the sum of both squares as they
    // will stand after this step (used on the final MUL cycle).
    always_comb begin
        acc_x_next = mp_x_reg[0] ? (acc_x_reg + mc_x_reg) : acc_x_reg;
        acc_y_next = mp_y_reg[0] ? (acc_y_reg + mc_y_reg) : acc_y_reg;
        sum_sq     = {1'b0, acc_x_next} + {1'b0, acc_y_next};
    end

    // One restoring square-root step: bring down two radicand bits and try
    // subtracting 4*root+1.
    always_comb begin
        rem_sh    = {rem_reg, rad_reg[RADW-1 -: 2]};
        trial     = (RW + 2)'({root_reg, 2'b01});
        sqrt_ge   = (rem_sh >= trial);
        rem_next  = sqrt_ge ? RW'(rem_sh - trial) : RW'(rem_sh);
        root_next = {root_reg[W-1:0], sqrt_ge};
    end

    // Datapath registers and phase counter; everything holds when no
    // enable is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_x_reg  <= '0;
            mc_y_reg  <= '0;
            mp_x_reg  <= '0;
            mp_y_reg  <= '0;
            acc_x_reg <= '0;
            acc_y_reg <= '0;
            rad_reg   <= '0;
            rem_reg   <= '0;
            root_reg  <= '0;
            cnt_reg   <= '0;
        end else if (start) begin
            mc_x_reg  <= AW'(x);
            mc_y_reg  <= AW'(y);
            mp_x_reg  <= x;
            mp_y_reg  <= y;
            acc_x_reg <= '0;
            acc_y_reg <= '0;
            rad_reg   <= '0;
            rem_reg   <= '0;
            root_reg  <= '0;
            cnt_reg   <= '0;
        end else if (mul_en) begin
            mc_x_reg  <= mc_x_reg << 1;
            mc_y_reg  <= mc_y_reg << 1;
            mp_x_reg  <= mp_x_reg >> 1;
            mp_y_reg  <= mp_y_reg >> 1;
            acc_x_reg <= acc_x_next;
            acc_y_reg <= acc_y_next;
            if (mul_last) begin
                cnt_reg  <= '0;
                rad_reg  <= RADW'(sum_sq);
                rem_reg  <= '0;
                root_reg <= '0;
            end else begin
                cnt_reg  <= cnt_reg + 1'b1;
            end
        end else if (sqrt_en) begin
            rad_reg  <= rad_reg << 2;
            rem_reg  <= rem_next;
            root_reg <= root_next;
            cnt_reg  <= sqrt_last ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/hyp_mag_sched.sv
// Round-robin scheduler sharing one hyp_mag_core among NREQ requesters.
// Grants one (x, y) pair at a time, runs the MUL and SQRT phases, and holds
// the result with the owner's id on a valid/ready response port.
module hyp_mag_sched
    import hyp_mag_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int W    = DEF_W,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W:0]        rsp_mag,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    localparam logic [1:0] IDLE = S_IDLE;
    localparam logic [1:0] MUL  = S_MUL;
    localparam logic [1:0] SQRT = S_SQRT;
    localparam logic [1:0] RESP = S_RESP;

    logic [1:0]     state_reg;
    logic [IDW-1:0] ptr_reg;        // last granted requester
    logic [IDW-1:0] own_id_reg;     // requester owning the job in flight
    logic           rsp_valid_reg;
    logic [W:0]     rsp_mag_reg;
    logic [IDW-1:0] rsp_id_reg;

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    logic           grant_ok;
    logic [W-1:0]   sel_x, sel_y;
    logic           mul_last, sqrt_last;
    logic [W:0]     root_next;

    // Round-robin search starting just after ptr. Walking from the lowest
    // priority to the highest lets the last hit be the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr_reg) + k) % NREQ);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign grant_ok = (state_reg == IDLE) && ena && win_found;
    assign sel_x    = req_x[win_idx*W +: W];
    assign sel_y    = req_y[win_idx*W +: W];
    assign busy     = (state_reg != IDLE);

    // One-hot ready to the winner only while idle and enabled.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_ok && (win_idx == IDW'(gi));
        end
    endgenerate

    hyp_mag_core #(
        .W(W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (grant_ok),
        .mul_en    (ena && (state_reg == MUL)),
        .sqrt_en   (ena && (state_reg == SQRT)),
        .x         (sel_x),
        .y         (sel_y),
        .mul_last  (mul_last),
        .sqrt_last (sqrt_last),
        .root_next (root_next)
    );

    // Scheduler FSM, arbitration pointer and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= IDW'(NREQ - 1);
            own_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_mag_reg   <= '0;
            rsp_id_reg    <= '0;
        end else if (ena) begin
            case (state_reg)
                IDLE: begin
                    if (grant_ok) begin
                        state_reg  <= MUL;
                        ptr_reg    <= win_idx;
                        own_id_reg <= win_idx;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        state_reg <= SQRT;
                    end
                end
                SQRT: begin
                    if (sqrt_last) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_mag_reg   <= root_next;
                        rsp_id_reg    <= own_id_reg;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_mag   = rsp_mag_reg;
    assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_hyp_mag_sched.sv
// Bench for hyp_mag_sched: directed transactions with literal expectations,
// plus a transaction-level reference model compared on every falling edge.
module tb_hyp_mag_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;
    localparam int LAT  = 2 * W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W:0]        rsp_mag;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    hyp_mag_sched #(
        .NREQ(NREQ),
        .W   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_mag   (rsp_mag),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int isqrt_floor(input int s);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (p + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int mag_of(input logic [NREQ*W-1:0] xb, input logic [NREQ*W-1:0] yb,
                                  input int i);
        int xv, yv;
        xv = int'(xb[i*W +: W]);
        yv = int'(yb[i*W +: W]);
        return isqrt_floor(xv * xv + yv * yv);
    endfunction

    bit m_busy = 1'b0;   // a job is owned (anything but idle)
    bit m_rv   = 1'b0;   // response presented
    int m_cnt  = 0;      // enabled cycles left before the response appears
    int m_ptr  = NREQ - 1;
    int m_mag  = 0;
    int m_id   = 0;
    int p_mag  = 0;
    int p_id   = 0;

    // Model advance: one transaction at a time, fixed enabled-cycle latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_rv   <= 1'b0;
            m_cnt  <= 0;
            m_ptr  <= NREQ - 1;
            m_mag  <= 0;
            m_id   <= 0;
        end else if (ena) begin
            if (!m_busy) begin
                if (rr_pick(req_valid, m_ptr) >= 0) begin
                    m_busy <= 1'b1;
                    m_cnt  <= LAT;
                    m_ptr  <= rr_pick(req_valid, m_ptr);
                    p_id   <= rr_pick(req_valid, m_ptr);
                    p_mag  <= mag_of(req_x, req_y, rr_pick(req_valid, m_ptr));
                end
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_rv  <= 1'b1;
                    m_mag <= p_mag;
                    m_id  <= p_id;
                end
            end else if (rsp_ready) begin
                m_rv   <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    int              cmp_pick;
    logic [NREQ-1:0] cmp_ready;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        cmp_ready = '0;
        cmp_pick  = rr_pick(req_valid, m_ptr);
        if (!m_busy && ena && (cmp_pick >= 0)) cmp_ready[cmp_pick] = 1'b1;
        chk("model_req_ready", int'(req_ready), int'(cmp_ready));
        chk("model_busy", int'(busy), int'(m_busy));
        chk("model_rsp_valid", int'(rsp_valid), int'(m_rv));
        chk("model_rsp_mag", int'(rsp_mag), m_mag);
        chk("model_rsp_id", int'(rsp_id), m_id);
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input int id, input int x, input int y);
        bit got;
        req_x[id*W +: W] = x[W-1:0];
        req_y[id*W +: W] = y[W-1:0];
        req_valid[id]    = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        chk("accept", int'(got), 1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    // Count edges from the accept edge to rsp_valid; optionally pulse ena low.
    task automatic wait_rsp(input int exp_mag, input int exp_id, input int exp_lat,
                            input int ena_at, input int ena_len);
        bit seen;
        int n;
        seen = 1'b0;
        n = 0;
        while (n < 80 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n == ena_at) ena = 1'b0;
            if (n == ena_at + ena_len) ena = 1'b1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("rsp_seen", int'(seen), 1);
        if (exp_lat >= 0) chk("latency", n, exp_lat);
        chk("rsp_mag", int'(rsp_mag), exp_mag);
        chk("rsp_id", int'(rsp_id), exp_id);
    endtask

    task automatic finish_rsp(input int exp_edges);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        while (n < 30 && !done) begin
            @(posedge clk);
            #1;
            n++;
            if (!rsp_valid) done = 1'b1;
        end
        chk("complete_edges", n, exp_edges);
    endtask

    int exp_ids[5]  = '{0, 1, 2, 3, 0};
    int exp_mags[5] = '{2, 4, 6, 8, 2};

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_mag", int'(rsp_mag), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester and extreme operands.
        issue(0, 3, 4);     wait_rsp(5, 0, 17, 0, 0);   finish_rsp(1);
        issue(0, 255, 255); wait_rsp(360, 0, 17, 0, 0); finish_rsp(1);
        issue(1, 0, 0);     wait_rsp(0, 1, 17, 0, 0);   finish_rsp(1);
        issue(2, 0, 200);   wait_rsp(200, 2, 17, 0, 0); finish_rsp(1);
        issue(3, 1, 1);     wait_rsp(1, 3, 17, 0, 0);   finish_rsp(1);

        // All requesters valid: rotation 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*W +: W] = W'(i + 1);
            req_y[i*W +: W] = W'(2 * (i + 1));
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(exp_mags[k], exp_ids[k], -1, 0, 0);
            if (k == 4) req_valid = '0;
            finish_rsp(1);
        end

        // Backpressure: response held for 10 cycles while another request waits.
        rsp_ready = 1'b0;
        issue(1, 5, 12);
        wait_rsp(13, 1, 17, 0, 0);
        req_x[2*W +: W] = 8'd9;
        req_y[2*W +: W] = 8'd9;
        req_valid[2] = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_mag", int'(rsp_mag), 13);
            chk("bp_rsp_id", int'(rsp_id), 1);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        rsp_ready    = 1'b1;
        req_valid[2] = 1'b0;
        finish_rsp(1);

        // ena low for 5 cycles mid-SQRT, then ena low in RESP.
        issue(0, 9, 12);
        wait_rsp(15, 0, 22, 12, 5);
        ena = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("ena_hold_valid", int'(rsp_valid), 1);
            chk("ena_hold_busy", int'(busy), 1);
        end
        ena = 1'b1;
        finish_rsp(1);

        // Reset mid-MUL aborts the job; priority restarts at requester 0.
        issue(1, 7, 7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", int'(req_ready), 0);
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_rsp_mag", int'(rsp_mag), 0);
        chk("abort_rsp_id", int'(rsp_id), 0);
        chk("abort_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        issue(2, 6, 8);
        wait_rsp(10, 2, 17, 0, 0);
        finish_rsp(1);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
